db_fsm: RTL and testbench

- One-bit switch debouncer built as an 8-state FSM, paced by a free-running tick generator.
- Sits between a raw mechanical switch/pushbutton input and synchronous logic.
- Output `db` changes only after the synchronized input has been stable across three consecutive ticks.
- Glitches shorter than that are rejected.

---
 rtl/db_pkg.sv | 28 ++
 rtl/db_tick_gen.sv | 30 +++
 rtl/db_fsm.sv | 74 +++++++
 tb/tb_db_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - shared types and constants for the switch debouncer
//
// Contents:
//   DB_N_DEFAULT : default tick counter width (simulation value)
//   db_state_t   : debouncer FSM state enum
//   db_level()   : debounced output level for a given state
package db_pkg;

  // 2 keeps simulation short; use 19 for ~10 ms at 50 MHz.
  localparam int DB_N_DEFAULT = 2;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } db_state_t;

  // The output holds 1 from ONE until a release has been fully confirmed.
  function automatic logic db_level(input db_state_t st);
    return (st == ONE) || (st == WAIT0_1) || (st == WAIT0_2) || (st == WAIT0_3);
  endfunction

endpackage

// File: rtl/db_tick_gen.sv
// rtl/db_tick_gen.sv - free-running tick generator pacing the debouncer
//
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset (counter cleared to 0)
//   tick  : one-cycle pulse whenever the counter reads 0 (every 2^N cycles)
module db_tick_gen
  import db_pkg::*;
#(
  parameter int N = DB_N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [N-1:0] q;

  // Wraps naturally from 2^N-1 back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q + 1'b1;
    end
  end

  assign tick = (q == '0);

endmodule

// File: rtl/db_fsm.sv
// rtl/db_fsm.sv - one-bit switch debouncer FSM with input synchronizer
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   sw    : raw, asynchronous, possibly bouncing switch level
//   db    : debounced switch level, registered
//
// db changes only after the synchronized input has stayed at the new level
// across three consecutive ticks; a reversal during a wait always wins over
// a coincident tick.
module db_fsm
  import db_pkg::*;
#(
  parameter int N = DB_N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db
);

  logic      sync1;
  logic      sync2;
  logic      tick;
  logic      db_next;
  db_state_t state;
  db_state_t state_next;

  db_tick_gen #(.N(N)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ZERO;
      db    <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      state <= state_next;
      db    <= db_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ZERO:    if (sync2)      state_next = WAIT1_1;
      WAIT1_1: if (!sync2)     state_next = ZERO;
               else if (tick)  state_next = WAIT1_2;
      WAIT1_2: if (!sync2)     state_next = ZERO;
               else if (tick)  state_next = WAIT1_3;
      WAIT1_3: if (!sync2)     state_next = ZERO;
               else if (tick)  state_next = ONE;
      ONE:     if (!sync2)     state_next = WAIT0_1;
      WAIT0_1: if (sync2)      state_next = ONE;
               else if (tick)  state_next = WAIT0_2;
      WAIT0_2: if (sync2)      state_next = ONE;
               else if (tick)  state_next = WAIT0_3;
      WAIT0_3: if (sync2)      state_next = ONE;
               else if (tick)  state_next = ZERO;
      default:                 state_next = ZERO;
    endcase
    // db is registered from the next state so it is a clean flop output
    // that moves on the same edge as the state register.
    db_next = db_level(state_next);
  end

endmodule

// File: tb/tb_db_fsm.sv
// tb/tb_db_fsm.sv - scoreboard bench for db_fsm against a tick-counting model
module tb_db_fsm;

  localparam int N      = 2;
  localparam int PERIOD = 1 << N;

  logic clk;
  logic rst_n;
  logic sw;
  logic db;

  int checks;
  int errors;

  bit exp_q[$];

  // Reference model: the synchronized level must differ from the output
  // and then survive three ticks (counted on later edges) to be adopted.
  int m_phase;
  bit m_s1, m_s2, m_db, m_pend;
  int m_ticks;

  db_fsm #(.N(N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .sw    (sw),
    .db    (db)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_phase = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
    m_db    = 1'b0;
    m_pend  = 1'b0;
    m_ticks = 0;
  endtask

  task automatic model_step();
    bit s;
    bit tk;
    if (!rst_n) begin
      model_reset();
    end else begin
      s  = m_s2;
      tk = (m_phase == 0);
      if (s == m_db) begin
        m_pend = 1'b0;
      end else if (!m_pend) begin
        m_pend  = 1'b1;
        m_ticks = 0;
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == 3) begin
          m_db   = s;
          m_pend = 1'b0;
        end
      end
      m_phase = (m_phase + 1) % PERIOD;
      m_s2    = m_s1;
      m_s1    = sw;
    end
    exp_q.push_back(m_db);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  // Model stepping on every rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  always @(negedge rst_n) model_reset();

  // Monitor: compare the registered output away from the active edge.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard_db", db, e);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    sw = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive a new level and count edges until db follows it (bounded).
  task automatic measure(input logic v, input string name, input int total);
    int cnt;
    sw  = v;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (db == v) break;
    end
    checks++;
    if (cnt < 12 || cnt > 15 || db !== v) begin
      errors++;
      $display("FAIL %s: latency %0d db %0b required 12..15 and %0b", name, cnt, db, v);
    end
    if (total > cnt) repeat (total - cnt) @(negedge clk);
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, db, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sw     = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_db", db, 1'b0);
    #2 rst_n = 1'b1;

    // Idle low stays low.
    hold(1'b0, 20);
    check("idle_low", db, 1'b0);

    // Clean press and release.
    measure(1'b1, "press_latency", 20);
    measure(1'b0, "release_latency", 20);
    measure(1'b1, "press2_latency", 20);
    measure(1'b0, "release2_latency", 300);
    check("stays_low", db, 1'b0);

    // Bounce rejection from db=0.
    hold(1'b1, 1); hold(1'b0, 4);
    hold(1'b1, 3); hold(1'b0, 4);
    hold(1'b1, 8); hold(1'b0, 20);
    check("bounce_reject_low", db, 1'b0);

    // Bounce rejection from db=1.
    hold(1'b1, 20);
    check("high_before_bounce", db, 1'b1);
    hold(1'b0, 1); hold(1'b1, 4);
    hold(1'b0, 3); hold(1'b1, 4);
    hold(1'b0, 8); hold(1'b1, 20);
    check("bounce_reject_high", db, 1'b1);

    // Asynchronous reset while db=1; full latency again after release.
    async_reset("reset_while_high");
    measure(1'b1, "post_reset_latency", 10);

    // Asynchronous reset while in WAIT1_2: release aligns phase so that
    // WAIT1_2 spans edges 5..8 after release.
    @(negedge clk);
    sw = 1'b0;
    async_reset("reset_clear");
    sw = 1'b1;
    repeat (6) @(negedge clk);
    async_reset("reset_in_wait1_2");
    measure(1'b1, "wait_reset_latency", 16);

    // Tick/reversal collision in WAIT1_3: sync2 drops on edge 13 after
    // release, which is also a tick edge.
    sw = 1'b0;
    async_reset("reset_before_collision");
    hold(1'b1, 10);
    hold(1'b0, 20);
    check("collision_stays_low", db, 1'b0);

    // Randomized runs checked by the scoreboard.
    for (int i = 0; i < 120; i++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 20));
    end
    hold(1'b0, 20);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
